// File: rtl/cpu_wb_pkg.sv
// ============================================================================
//  Module      : cpu_wb_pkg
//  Description : Shared constants, bridge FSM state encoding and a helper
//                that picks the first beat of a request.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_wb_pkg;

    localparam int WB_AW  = 16;
    localparam int WB_DW  = 16;
    localparam int CPU_DW = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_RESP = 2'd3
    } wb_state_e;

    // A request starts on the lowest enabled half; with no enables at all it
    // goes straight to the response without touching the bus.
    function automatic wb_state_e first_beat(input logic [3:0] be);
        if (be[1:0] != 2'b00) begin
            return ST_LO;
        end else if (be[3:2] != 2'b00) begin
            return ST_HI;
        end else begin
            return ST_RESP;
        end
    endfunction

endpackage

`default_nettype wire

// File: rtl/wb_timeout_cnt.sv
// ============================================================================
//  Module      : wb_timeout_cnt
//  Description : Per-beat acknowledge watchdog. Loaded with TIMEOUT on entry
//                to a beat, counts down while the beat is active and flags
//                expiry on the last permitted strobe cycle. Disabled when
//                TIMEOUT is 0.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_timeout_cnt #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic en_i,
    output logic expired_o
);

    generate
        if (TIMEOUT == 0) begin : g_off
            assign expired_o = 1'b0;
        end else begin : g_on
            localparam int CW = $clog2(TIMEOUT + 1);
            localparam logic [CW-1:0] C_LOAD = CW'(TIMEOUT);
            localparam logic [CW-1:0] C_LAST = CW'(1);

            logic [CW-1:0] cnt_q;
            logic [CW-1:0] cnt_d;

            // Reload on beat entry, otherwise count down while the beat is live.
            always_comb begin
                cnt_d = cnt_q;
                if (load_i) begin
                    cnt_d = C_LOAD;
                end else if (en_i && (cnt_q != '0)) begin
                    cnt_d = cnt_q - C_LAST;
                end
            end

            // Counter register.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            // The value 1 marks the TIMEOUT-th strobe cycle of the beat.
            assign expired_o = en_i && (cnt_q == C_LAST);
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/wb_master_bridge.sv
// ============================================================================
//  Module      : wb_master_bridge
//  Description : Turns one 32-bit core request into up to two 16-bit
//                Wishbone classic beats (low half then high half), gathers
//                read data and returns a single one-cycle response.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_master_bridge
    import cpu_wb_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [WB_AW-1:0]  req_addr,
    input  logic [CPU_DW-1:0] req_wdata,
    input  logic [3:0]        req_be,
    output logic              rsp_valid,
    output logic [CPU_DW-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [WB_AW-1:0]  adr_out,
    output logic [WB_DW-1:0]  data_out,
    input  logic [WB_DW-1:0]  data_in,
    output logic              we,
    output logic [3:0]        sel_out,
    output logic              stb_out,
    output logic              cyc_out,
    input  logic              ack_in
);

    wb_state_e         state_q, state_d;
    logic [WB_AW-1:0]  addr_q, addr_d;
    logic [CPU_DW-1:0] wdata_q, wdata_d;
    logic [3:0]        be_q, be_d;
    logic              rwe_q, rwe_d;
    logic [CPU_DW-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    // Bus outputs are registered so they appear the cycle after the
    // decision that produces them.
    logic [WB_AW-1:0]  adr_q, adr_d;
    logic [WB_DW-1:0]  dout_q, dout_d;
    logic [3:0]        sel_q, sel_d;
    logic              wbwe_q, wbwe_d;
    logic              cyc_q, cyc_d;
    logic              stb_q, stb_d;

    logic              in_beat;
    logic              beat_next;
    logic              cnt_load;
    logic              expired;

    assign in_beat   = (state_q == ST_LO) || (state_q == ST_HI);
    assign beat_next = (state_d == ST_LO) || (state_d == ST_HI);
    assign cnt_load  = beat_next && (state_d != state_q);

    wb_timeout_cnt #(
        .TIMEOUT   (TIMEOUT)
    ) u_timeout (
        .clk       (clk),
        .rst       (rst),
        .load_i    (cnt_load),
        .en_i      (in_beat),
        .expired_o (expired)
    );

    // Next-state, request latch, read-data gather and registered bus drive.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        rwe_d   = rwe_q;
        rdata_d = rdata_q;
        err_d   = err_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    addr_d  = {req_addr[WB_AW-1:1], 1'b0};
                    wdata_d = req_wdata;
                    be_d    = req_be;
                    rwe_d   = req_we;
                    rdata_d = '0;
                    err_d   = 1'b0;
                    state_d = first_beat(req_be);
                end
            end
            ST_LO: begin
                // An acknowledge on the expiry cycle still completes the beat.
                if (ack_in) begin
                    if (!rwe_q) begin
                        rdata_d[15:0] = data_in;
                    end
                    state_d = (be_q[3:2] != 2'b00) ? ST_HI : ST_RESP;
                end else if (expired) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_HI: begin
                if (ack_in) begin
                    if (!rwe_q) begin
                        rdata_d[31:16] = data_in;
                    end
                    state_d = ST_RESP;
                end else if (expired) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        cyc_d  = beat_next;
        stb_d  = beat_next;
        adr_d  = '0;
        dout_d = '0;
        sel_d  = 4'b0000;
        wbwe_d = 1'b0;
        if (state_d == ST_LO) begin
            adr_d  = addr_d;
            dout_d = wdata_d[15:0];
            sel_d  = {2'b00, be_d[1:0]};
            wbwe_d = rwe_d;
        end else if (state_d == ST_HI) begin
            // The high half address wraps within the 16-bit space.
            adr_d  = addr_d + 16'd2;
            dout_d = wdata_d[31:16];
            sel_d  = {2'b00, be_d[3:2]};
            wbwe_d = rwe_d;
        end
    end

    // State, request and bus registers; reset abandons any bus cycle at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= 4'b0000;
            rwe_q   <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            adr_q   <= '0;
            dout_q  <= '0;
            sel_q   <= 4'b0000;
            wbwe_q  <= 1'b0;
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rwe_q   <= rwe_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            adr_q   <= adr_d;
            dout_q  <= dout_d;
            sel_q   <= sel_d;
            wbwe_q  <= wbwe_d;
            cyc_q   <= cyc_d;
            stb_q   <= stb_d;
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign adr_out   = adr_q;
    assign data_out  = dout_q;
    assign sel_out   = sel_q;
    assign we        = wbwe_q;
    assign cyc_out   = cyc_q;
    assign stb_out   = stb_q;

endmodule

`default_nettype wire

// File: doc/wb_master_bridge.md
# wb_master_bridge

Wishbone master bridge between the CPU core's load/store/fetch port and the 16-bit Wishbone bus. Accepts one 32-bit request at a time from the core, splits it into up to two 16-bit Wishbone classic beats (low half, then high half), gathers read data, and returns a single response. Sits directly upstream of the Wishbone interconnect and drives the `wishbone` interface master signals.

## Interface
- `TIMEOUT`, default 64: cycles waiting for `ack_in` per beat before abort; 0 disables timeout.
- `clk`  in  1  system clock, all logic on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `req_valid`  in  1  core request present
- `req_ready`  out  1  bridge can accept; high only in IDLE
- `req_we`  in  1  1 write, 0 read
- `req_addr`  in  16  byte address; bit 0 ignored (treated as 0)
- `req_wdata`  in  32  write data; [15:0] low beat, [31:16] high beat
- `req_be`  in  4  byte enables; [1:0] low beat, [3:2] high beat
- `rsp_valid`  out  1  one-cycle completion pulse, no backpressure
- `rsp_rdata`  out  32  read data, valid with `rsp_valid`; disabled half reads 0
- `rsp_err`  out  1  timeout abort, valid with `rsp_valid`
- `adr_out`  out  16  Wishbone address
- `data_out`  out  16  Wishbone write data
- `data_in`  in  16  Wishbone read data
- `we`  out  1  Wishbone write enable (low read, high write)
- `sel_out`  out  4  {2'b00, beat byte enables}
- `stb_out`  out  1  Wishbone strobe
- `cyc_out`  out  1  Wishbone cycle
- `ack_in`  in  1  Wishbone acknowledge

## Operation
- Reset values: `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, `adr_out`=0, `data_out`=0, `we`=0, `sel_out`=0, `stb_out`=0, `cyc_out`=0.
- FSM states: IDLE, LO, HI, RESP.
- IDLE: on `req_valid`, latch addr/wdata/be/we. Next state LO if be[1:0]!=0, else HI if be[3:2]!=0, else RESP (no bus cycle, rdata=0, err=0).
- LO: `cyc_out`=`stb_out`=1, `adr_out`=addr, `data_out`=wdata[15:0], `sel_out`={2'b00,be[1:0]}. On `ack_in`: capture `data_in` into rdata[15:0] if read; go HI if be[3:2]!=0 else RESP.
- HI: same with `adr_out`=addr+2 (16-bit wrap: 0xFFFE+2=0x0000), wdata[31:16], be[3:2]; capture into rdata[31:16]. On `ack_in` go RESP.
- `cyc_out` held high continuously from first beat through last ack; `stb_out` never drops between LO and HI.
- Timeout: per-beat counter clears on entry to LO/HI; if it reaches `TIMEOUT` without `ack_in`, drop `cyc_out`/`stb_out`, go RESP with `rsp_err`=1, rdata=0; HI not issued after LO timeout.
- RESP: `rsp_valid`=1 for exactly one cycle, then IDLE.
- `ack_in` in IDLE or RESP ignored. `ack_in` and timeout in same cycle: ack wins.

## Timing
- Request handshake: transfer when `req_valid`&&`req_ready`; bus signals registered, asserted the cycle after acceptance.
- Zero-wait-state two-beat access: accept at cycle 0, LO beat cycle 1 (ack), HI beat cycle 2 (ack), `rsp_valid` cycle 3, `req_ready` high cycle 4.
- Single-beat: `rsp_valid` cycle 2. Null (be=0): `rsp_valid` cycle 1.
- Each wait state on `ack_in` adds one cycle to that beat.
- Timeout beat asserts stb for exactly `TIMEOUT` cycles; `rsp_valid` next cycle.
- `rst` low at any time: all outputs to reset values immediately (asynchronous), bus cycle abandoned, no response.

## Structure
- Package `cpu_wb_pkg`: FSM state enum, `WB_AW`=16, `WB_DW`=16, `CPU_DW`=32 constants.
- Sub-module `wb_timeout_cnt`: loadable down-counter, width `$clog2(TIMEOUT+1)`, outputs `expired`; held off when `TIMEOUT`=0.

## Test plan
- Read be=4'hF addr=0x1000, slave returns 0xBEEF @0x1000, 0xDEAD @0x1002, zero wait -> `rsp_rdata`=0xDEADBEEF, `rsp_err`=0, `rsp_valid` at cycle 3, `cyc_out` high cycles 1-2 unbroken.
- Write be=4'b1100 addr=0x2000 wdata=0x12345678 -> single beat `adr_out`=0x2002, `data_out`=0x1234, `sel_out`=4'b0011, `we`=1; no access to 0x2000.
- Read addr=0xFFFE be=4'hF -> beats at 0xFFFE then 0x0000.
- TIMEOUT=8, slave never acks -> `stb_out` high exactly 8 cycles, `rsp_err`=1, `rsp_rdata`=0, HI beat never issued.
- Slave inserts 3 wait states on LO; stray `ack_in` while IDLE -> response at cycle 6, stray ack has no effect.
- `rst` low during HI beat -> `cyc_out`/`stb_out` drop same cycle, no `rsp_valid`, `req_ready`=1 after release.
